count_reg_arbiter: RTL and testbench

Shares the single 12-bit negedge-captured count register between up to NREQ requesters in the counting system. Arbitrates round-robin, computes the next register value (load / add / subtract / clear) from the register's live output, drives the register's data input, and acknowledges each requester once the new value has been captured. Sits between the requester blocks and the count register; it is the only driver of that register's data input.

---
 rtl/count_sys_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/count_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_count_reg_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sys_pkg.sv
// Shared types for the counting system: count register width, opcodes and
// the arbiter FSM states.
package count_sys_pkg;

  localparam int COUNT_W = 12;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    ADD   = 2'b01,
    SUB   = 2'b10,
    CLEAR = 2'b11
  } count_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest eligible index at or above i_ptr,
// otherwise lowest eligible index overall. Output is one-hot (or zero).
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_mask,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_win
);

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_below_ptr;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pick;

  assign w_elig      = i_req & i_mask;
  assign w_below_ptr = (NREQ'(1) << i_ptr) - NREQ'(1);
  assign w_hi        = w_elig & ~w_below_ptr;
  assign w_pick      = (|w_hi) ? w_hi : w_elig;
  // Isolate the lowest set bit of the chosen half.
  assign o_win       = w_pick & (~w_pick + NREQ'(1));

endmodule

// File: rtl/count_reg_arbiter.sv
// Round-robin owner of the shared negedge count register's data input.
// Optional readback check enabled by defining COUNT_ARB_READBACK_EN.
module count_reg_arbiter
  import count_sys_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = COUNT_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [2*NREQ-1:0]       i_op,
  input  logic [WIDTH*NREQ-1:0]   i_operand,
  input  logic [WIDTH-1:0]        i_reg_q,
  output logic [WIDTH-1:0]        o_reg_d,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_ack,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_wrap,
  output logic                    o_err
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_e        r_state;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   r_idx;
  count_op_e         r_op;
  logic [WIDTH-1:0]  r_operand;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_reg_d;
  logic              r_flag;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_wrap;

  logic [NREQ-1:0]   w_win;
  logic [IDXW-1:0]   w_win_idx;
  logic [1:0]        w_sel_op;
  logic [WIDTH-1:0]  w_sel_opnd;

  // Top bit carries the ADD carry / SUB borrow; zero for LOAD and CLEAR.
  function automatic logic [WIDTH:0] next_val(input logic [WIDTH-1:0] q,
                                               input count_op_e        op,
                                               input logic [WIDTH-1:0] opnd);
    case (op)
      LOAD:    return {1'b0, opnd};
      ADD:     return {1'b0, q} + {1'b0, opnd};
      SUB:     return {1'b0, q} - {1'b0, opnd};
      default: return '0;
    endcase
  endfunction

  // A requester being acked this cycle is masked so a late release is ignored.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req  (i_req),
    .i_mask (~r_ack),
    .i_ptr  (r_ptr),
    .o_win  (w_win)
  );

  always_comb begin
    w_win_idx  = '0;
    w_sel_op   = '0;
    w_sel_opnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = IDXW'(i);
        w_sel_op   = i_op[2*i +: 2];
        w_sel_opnd = i_operand[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_op      <= LOAD;
      r_operand <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_reg_d   <= '0;
      r_flag    <= 1'b0;
      r_rdata   <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|w_win) begin
            r_gnt     <= w_win;
            r_idx     <= w_win_idx;
            r_op      <= count_op_e'(w_sel_op);
            r_operand <= w_sel_opnd;
            r_state   <= APPLY;
          end
        end
        APPLY: begin
          {r_flag, r_reg_d} <= next_val(i_reg_q, r_op, r_operand);
          r_state           <= CHECK;
        end
        CHECK: begin
          r_rdata <= i_reg_q;
          r_wrap  <= r_flag;
          r_ack   <= r_gnt;
          r_gnt   <= '0;
          r_ptr   <= (r_idx == IDXW'(NREQ-1)) ? '0 : r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef COUNT_ARB_READBACK_EN
  logic r_err;

  // Register should hold exactly what APPLY drove by the time CHECK samples it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == CHECK && i_reg_q != r_reg_d) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_reg_d = r_reg_d;
  assign o_gnt   = r_gnt;
  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;
  assign o_wrap  = r_wrap;

endmodule

// File: tb/tb_count_reg_arbiter.sv
// Scoreboard bench for count_reg_arbiter driving a negedge count register model.
// Readback expectations follow COUNT_ARB_READBACK_EN.
module tb_count_reg_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [2*NREQ-1:0]   op = '0;
  logic [W*NREQ-1:0]   operand = '0;
  logic [W-1:0]        reg_q_real = '0;
  logic [W-1:0]        reg_q_dut;
  logic                zero_rb = 1'b0;
  logic [W-1:0]        reg_d, rdata;
  logic [NREQ-1:0]     gnt, ack;
  logic                wrap, err;

  typedef struct {
    int         idx;
    logic [W-1:0] rd;
    logic       wr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          ack_cyc[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [W-1:0] model = '0;
  logic        exp_err;
  logic [W-1:0] rb_rdata;

  always #5 clk = ~clk;

  // The shared count register captures on the falling edge.
  always @(negedge clk) reg_q_real <= reg_d;
  assign reg_q_dut = zero_rb ? '0 : reg_q_real;

  count_reg_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_op      (op),
    .i_operand (operand),
    .i_reg_q   (reg_q_dut),
    .o_reg_d   (reg_d),
    .o_gnt     (gnt),
    .o_ack     (ack),
    .o_rdata   (rdata),
    .o_wrap    (wrap),
    .o_err     (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (ack != '0) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_idx", 32'(ack), 32'(1) << mon_e.idx);
        check("rdata", 32'(rdata), 32'(mon_e.rd));
        check("wrap", 32'(wrap), 32'(mon_e.wr));
        ack_cyc.push_back(cyc);
      end
    end
  end

  function automatic void calc(input logic [W-1:0] q, input logic [1:0] o,
                               input logic [W-1:0] a, output logic [W-1:0] r,
                               output logic c);
    int s;
    case (o)
      OP_LOAD: begin r = a; c = 1'b0; end
      OP_ADD:  begin s = int'(q) + int'(a); r = W'(s); c = (s > 4095); end
      OP_SUB:  begin s = int'(q) - int'(a); r = W'(s); c = (s < 0); end
      default: begin r = '0; c = 1'b0; end
    endcase
  endfunction

  task automatic expect_op(input int i, input logic [1:0] o, input logic [W-1:0] a);
    logic [W-1:0] r;
    logic c;
    calc(model, o, a, r, c);
    model = r;
    sb.push_back('{i, r, c});
  endtask

  task automatic drive(input int i, input logic [1:0] o, input logic [W-1:0] a);
    req[i] = 1'b1;
    op[2*i +: 2] = o;
    operand[W*i +: W] = a;
  endtask

  task automatic wait_ack(input int i);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (ack[i]) return;
    end
    check("ack_timeout", 32'(ack), 32'(1) << i);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_gnt"},   32'(gnt),   32'd0);
    check({tag, "_ack"},   32'(ack),   32'd0);
    check({tag, "_reg_d"}, 32'(reg_d), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_wrap"},  32'(wrap),  32'd0);
    check({tag, "_err"},   32'(err),   32'd0);
  endtask

  // Single-requester operation with edge-by-edge timing checks.
  task automatic do_op(input int i, input logic [1:0] o, input logic [W-1:0] a);
    @(posedge clk); #1;
    expect_op(i, o, a);
    drive(i, o, a);
    @(posedge clk); #1;
    check("gnt_E0", 32'(gnt), 32'(1) << i);
    check("ack_E0", 32'(ack), 32'd0);
    @(posedge clk); #1;
    check("gnt_E1", 32'(gnt), 32'(1) << i);
    check("reg_d_E1", 32'(reg_d), 32'(model));
    @(posedge clk); #1;
    check("ack_E2", 32'(ack), 32'(1) << i);
    check("gnt_E2", 32'(gnt), 32'd0);
    check("reg_q_E2", 32'(reg_q_real), 32'(model));
    req[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
`ifdef COUNT_ARB_READBACK_EN
    exp_err  = 1'b1;
    rb_rdata = '0;
`else
    exp_err  = 1'b0;
    rb_rdata = 12'h123;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_zero_outs("rst");
    @(negedge clk); #1;
    check("rst_reg_q", 32'(reg_q_real), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model = '0;

    do_op(0, OP_LOAD, 12'h5A5);
    do_op(1, OP_LOAD, 12'hFFE);
    do_op(1, OP_ADD,  12'h003);
    do_op(1, OP_SUB,  12'h002);
    do_op(2, OP_CLR,  12'h555);

    // All four requesting from reset: fair rotation 0,1,2,3,0.
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) drive(i, OP_LOAD, W'(12'h100 + i));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model = '0;
    ack_cyc.delete();
    for (int i = 0; i < NREQ; i++) expect_op(i, OP_LOAD, W'(12'h100 + i));
    expect_op(0, OP_LOAD, 12'h100);
    for (int n = 0; n < 5; n++) begin
      for (int t = 0; t < 20; t++) begin
        @(posedge clk); #1;
        if (ack != '0) break;
      end
    end
    req = '0;
    #1;
    check("rr_ack_count", 32'(ack_cyc.size()), 32'd5);
    if (ack_cyc.size() == 5)
      for (int k = 1; k < 5; k++) check("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);

    // Requester 2 releases one cycle late while 3 waits.
    @(posedge clk); #1;
    expect_op(2, OP_LOAD, 12'h222);
    expect_op(3, OP_LOAD, 12'h333);
    drive(2, OP_LOAD, 12'h222);
    drive(3, OP_LOAD, 12'h333);
    wait_ack(2);
    @(posedge clk); #1;
    check("late_gnt3", 32'(gnt), 32'b1000);
    req[2] = 1'b0;
    wait_ack(3);
    req[3] = 1'b0;

    // Late release with nobody else waiting must not regrant.
    @(posedge clk); #1;
    expect_op(2, OP_ADD, 12'h011);
    drive(2, OP_ADD, 12'h011);
    wait_ack(2);
    @(posedge clk); #1;
    check("late_nogrant", 32'(gnt), 32'd0);
    req[2] = 1'b0;
    @(posedge clk); #1;
    check("late_idle", 32'(gnt), 32'd0);

    // Reset while the operation is in APPLY.
    @(posedge clk); #1;
    drive(1, OP_LOAD, 12'h777);
    @(posedge clk); #1;
    check("mid_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero_outs("midrst");
    req[1] = 1'b0;
    @(negedge clk); #1;
    check("midrst_reg_q", 32'(reg_q_real), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model = '0;
    repeat (4) @(posedge clk);
    #1;
    do_op(1, OP_LOAD, 12'h001);

    // Readback: register view forced to zero during CHECK.
    @(posedge clk); #1;
    sb.push_back('{0, rb_rdata, 1'b0});
    model = 12'h123;
    drive(0, OP_LOAD, 12'h123);
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef COUNT_ARB_READBACK_EN
    zero_rb = 1'b1;
`endif
    @(posedge clk); #1;
    zero_rb = 1'b0;
    check("rb_ack", 32'(ack), 32'b0001);
    check("rb_err", 32'(err), 32'(exp_err));
    req[0] = 1'b0;
    do_op(3, OP_ADD, 12'h001);
    check("rb_err_sticky", 32'(err), 32'(exp_err));

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
